// File: rtl/memwb_pkg.sv
// MEM/WB boundary shared definitions: WB control bit positions,
// default field widths and the entry layout.
package memwb_pkg;

    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    localparam int DATA_W_DEF = 16;
    localparam int REG_AW_DEF = 3;
    localparam int WB_W_DEF   = 2;

    typedef struct packed {
        logic [WB_W_DEF-1:0]   wb;
        logic [DATA_W_DEF-1:0] rdata;
        logic [DATA_W_DEF-1:0] alu;
        logic [REG_AW_DEF-1:0] treg;
    } memwb_entry_t;

    localparam int ENTRY_W = $bits(memwb_entry_t);

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush.
// in_ready is taken straight from the skid-valid flop.
module pipe_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         mainValid;
    logic         skidValid;
    logic [W-1:0] mainData;
    logic [W-1:0] skidData;
    logic         inFire;
    logic         mainFree;

    assign in_ready  = ~skidValid;
    assign out_valid = mainValid;
    assign out_data  = mainData;

    assign inFire   = in_valid & ~skidValid;
    assign mainFree = ~mainValid | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mainValid <= 1'b0;
            skidValid <= 1'b0;
            mainData  <= '0;
            skidData  <= '0;
        end else if (flush) begin
            mainValid <= 1'b0;
            skidValid <= 1'b0;
        end else if (skidValid) begin
            // Skid only fills while main is held, so main is valid here.
            if (out_ready) begin
                mainData  <= skidData;
                skidValid <= 1'b0;
            end
        end else if (inFire) begin
            if (mainFree) begin
                mainData  <= in_data;
                mainValid <= 1'b1;
            end else begin
                skidData  <= in_data;
                skidValid <= 1'b1;
            end
        end else if (mainValid && out_ready) begin
            mainValid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_wb_stage_buf.sv
// MEM/WB pipeline boundary with skid buffer and write-back decode.
// Optional EX forwarding outputs when MEMWB_FWD_EN is defined.
module mem_wb_stage_buf
    import memwb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int WB_W   = WB_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WB_W-1:0]   wb_in,
    input  logic [DATA_W-1:0] rdata_in,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [REG_AW-1:0] treg_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WB_W-1:0]   wb_out,
    output logic [DATA_W-1:0] rdata_out,
    output logic [DATA_W-1:0] alu_out,
    output logic [REG_AW-1:0] treg_out,
`ifdef MEMWB_FWD_EN
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_reg,
    output logic [DATA_W-1:0] fwd_data,
`endif
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data
);

    // Same layout as memwb_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [WB_W-1:0]   wb;
        logic [DATA_W-1:0] rdata;
        logic [DATA_W-1:0] alu;
        logic [REG_AW-1:0] treg;
    } entryT;

    localparam int EW = $bits(entryT);

    entryT inEntry;
    entryT outEntry;

    assign inEntry = '{
        wb:    wb_in,
        rdata: rdata_in,
        alu:   alu_in,
        treg:  treg_in
    };

    pipe_skid_buf #(
        .W(EW)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (inEntry),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (outEntry)
    );

    assign wb_out    = outEntry.wb;
    assign rdata_out = outEntry.rdata;
    assign alu_out   = outEntry.alu;
    assign treg_out  = outEntry.treg;

    assign wr_en   = out_valid & wb_out[WB_REGWRITE];
    assign wr_data = wb_out[WB_MEMTOREG] ? rdata_out : alu_out;

`ifdef MEMWB_FWD_EN
    // Register 0 is hardwired, so it is never a forwarding source.
    assign fwd_valid = wr_en & (treg_out != '0);
    assign fwd_reg   = treg_out;
    assign fwd_data  = wr_data;
`endif

endmodule
